// File: rtl/regfile_mp.sv
// regfile_mp: two-write / two-read register file with optional hardwired
// zero register, same-cycle write-to-read bypass and a per-register pending
// scoreboard for long-latency producers.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnableA,
  input  logic [ADDR_W-1:0] ctrl_writeRegA,
  input  logic [DATA_W-1:0] data_writeRegA,
  input  logic              ctrl_writeEnableB,
  input  logic [ADDR_W-1:0] ctrl_writeRegB,
  input  logic [DATA_W-1:0] data_writeRegB,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_reg,
  output logic [ADDR_W:0]   pending_count,
  output logic              write_collision
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_W:0]   count_next;

  logic a_zero;
  logic b_zero;
  logic same_dest;
  logic wr_a;
  logic wr_b;
  logic set_ok;
  logic collision_next;

  // Qualify the write and scoreboard requests (zero register, port A priority).
  always_comb begin
    a_zero         = (ZERO_REG != 0) && (ctrl_writeRegA == '0);
    b_zero         = (ZERO_REG != 0) && (ctrl_writeRegB == '0);
    same_dest      = ctrl_writeEnableA && ctrl_writeEnableB &&
                     (ctrl_writeRegA == ctrl_writeRegB);
    wr_a           = ctrl_writeEnableA && !a_zero;
    wr_b           = ctrl_writeEnableB && !b_zero && !same_dest;
    set_ok         = sb_set_en && !((ZERO_REG != 0) && (sb_set_reg == '0));
    collision_next = same_dest && !a_zero;
  end

  // Next pending vector: port B clears, a new issue sets; set is applied last so it wins.
  always_comb begin
    pending_next = pending;
    if (ctrl_writeEnableB) pending_next[ctrl_writeRegB] = 1'b0;
    if (set_ok)            pending_next[sb_set_reg]     = 1'b1;
    if (ZERO_REG != 0)     pending_next[0]              = 1'b0;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_W{1'b0}}, pending_next[i]};
    end
  end

  // Register array: both ports write at the edge; reset clears every entry.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_a) mem[ctrl_writeRegA] <= data_writeRegA;
      if (wr_b) mem[ctrl_writeRegB] <= data_writeRegB;
    end
  end

  // Scoreboard state, its population count and the collision pulse.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pending         <= '0;
      pending_count   <= '0;
      write_collision <= 1'b0;
    end else begin
      pending         <= pending_next;
      pending_count   <= count_next;
      write_collision <= collision_next;
    end
  end

  // Read port A: stored data, optionally overridden by this cycle's writes (A over B).
  always_comb begin
    data_readRegA = mem[ctrl_readRegA];
    busy_readRegA = pending[ctrl_readRegA];
    if (BYPASS != 0) begin
      if (ctrl_writeEnableB && (ctrl_writeRegB == ctrl_readRegA)) begin
        data_readRegA = data_writeRegB;
        busy_readRegA = 1'b0;
      end
      if (ctrl_writeEnableA && (ctrl_writeRegA == ctrl_readRegA)) begin
        data_readRegA = data_writeRegA;
      end
    end
    if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) begin
      data_readRegA = '0;
      busy_readRegA = 1'b0;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    data_readRegB = mem[ctrl_readRegB];
    busy_readRegB = pending[ctrl_readRegB];
    if (BYPASS != 0) begin
      if (ctrl_writeEnableB && (ctrl_writeRegB == ctrl_readRegB)) begin
        data_readRegB = data_writeRegB;
        busy_readRegB = 1'b0;
      end
      if (ctrl_writeEnableA && (ctrl_writeRegA == ctrl_readRegB)) begin
        data_readRegB = data_writeRegA;
      end
    end
    if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) begin
      data_readRegB = '0;
      busy_readRegB = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus for regfile_mp
// (DATA_W=32, ADDR_W=5, ZERO_REG=1, BYPASS=1) with a queue-based scoreboard.
module tb_regfile_mp;

  logic        clock;
  logic        ctrl_reset_n;
  logic        wea, web, sb_en;
  logic [4:0]  wra, wrb, rra, rrb, sb_reg;
  logic [31:0] da, db;
  logic [31:0] rda, rdb;
  logic        busya, busyb;
  logic [5:0]  pcount;
  logic        coll;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnableA(wea),
    .ctrl_writeRegA   (wra),
    .data_writeRegA   (da),
    .ctrl_writeEnableB(web),
    .ctrl_writeRegB   (wrb),
    .data_writeRegB   (db),
    .ctrl_readRegA    (rra),
    .ctrl_readRegB    (rrb),
    .data_readRegA    (rda),
    .data_readRegB    (rdb),
    .busy_readRegA    (busya),
    .busy_readRegB    (busyb),
    .sb_set_en        (sb_en),
    .sb_set_reg       (sb_reg),
    .pending_count    (pcount),
    .write_collision  (coll)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic [5:0]  cnt;
    logic        coll;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_coll;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wea && wra == idx) return da;
    if (web && wrb == idx) return db;
    return m_regs[idx];
  endfunction

  function automatic logic m_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    return m_pend[idx] && !(web && wrb == idx);
  endfunction

  function automatic logic [5:0] m_count();
    int n = 0;
    foreach (m_pend[i]) n += int'(m_pend[i]);
    return 6'(n);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_coll = 1'b0;
  endtask

  // Apply one cycle of stimulus, queue the expected outputs, then advance the model.
  task automatic drive(input logic a_en, input logic [4:0] a_reg, input logic [31:0] a_dat,
                       input logic b_en, input logic [4:0] b_reg, input logic [31:0] b_dat,
                       input logic [4:0] r_a, input logic [4:0] r_b,
                       input logic s_en, input logic [4:0] s_reg);
    exp_t e;
    wea = a_en; wra = a_reg; da = a_dat;
    web = b_en; wrb = b_reg; db = b_dat;
    rra = r_a;  rrb = r_b;
    sb_en = s_en; sb_reg = s_reg;
    e.a    = m_read(r_a);
    e.b    = m_read(r_b);
    e.ba   = m_busy(r_a);
    e.bb   = m_busy(r_b);
    e.cnt  = m_count();
    e.coll = m_coll;
    exp_q.push_back(e);
    @(posedge clock);
    if (a_en && a_reg != 0) m_regs[a_reg] = a_dat;
    if (b_en && b_reg != 0 && !(a_en && a_reg == b_reg)) m_regs[b_reg] = b_dat;
    if (b_en) m_pend[b_reg] = 1'b0;
    if (s_en && s_reg != 0) m_pend[s_reg] = 1'b1;
    m_coll = a_en && b_en && (a_reg == b_reg) && (a_reg != 0);
    #1;
  endtask

  task automatic idle_read(input logic [4:0] r_a, input logic [4:0] r_b);
    drive(0, 0, 0, 0, 0, 0, r_a, r_b, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle once stimulus is applied; compare at the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rdA",   rda,           e.a);
      check("rdB",   rdb,           e.b);
      check("busyA", {31'h0, busya}, {31'h0, e.ba});
      check("busyB", {31'h0, busyb}, {31'h0, e.bb});
      check("count", {26'h0, pcount}, {26'h0, e.cnt});
      check("coll",  {31'h0, coll},  {31'h0, e.coll});
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_reset_n = 1'b0;
    wea = 0; web = 0; sb_en = 0;
    wra = 0; wrb = 0; rra = 0; rrb = 0; sb_reg = 0;
    da = 0; db = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset contents
    idle_read(0, 5);
    idle_read(31, 0);
    // Write r5, bypass same cycle, stored next cycle
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 31, 0, 0);
    idle_read(5, 5);
    // Zero register: write and scoreboard set ignored
    drive(1, 0, 32'h1234, 0, 0, 0, 0, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_read(0, 0);
    // Collision on r7: A wins, one-cycle pulse
    drive(1, 7, 32'h11, 1, 7, 32'h22, 7, 7, 0, 0);
    idle_read(7, 7);
    idle_read(7, 7);
    // Scoreboard set/clear on r3
    drive(0, 0, 0, 0, 0, 0, 3, 3, 1, 3);
    idle_read(3, 3);
    drive(0, 0, 0, 1, 3, 32'h99, 3, 3, 0, 0);
    idle_read(3, 3);
    // Set wins over clear on r9
    drive(0, 0, 0, 0, 0, 0, 9, 9, 1, 9);
    idle_read(9, 9);
    drive(0, 0, 0, 1, 9, 32'h55, 9, 9, 1, 9);
    idle_read(9, 9);
    // Clear r9 again before randomized phase
    drive(0, 0, 0, 1, 9, 32'h66, 9, 9, 0, 0);

    // Randomized phase; small index range to provoke conflicts
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    // Mark r1..r31 pending
    for (int r = 1; r < 32; r++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(r), 5'(r - 1), 1, 5'(r));
    end
    idle_read(9, 5);
    check("count31", {26'h0, pcount}, 32'd31);

    // Asynchronous reset between edges
    wea = 0; web = 0; sb_en = 0;
    rra = 5'd5; rrb = 5'd9;
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_rdA",   rda,              32'h0);
    check("rst_rdB",   rdb,              32'h0);
    check("rst_busyA", {31'h0, busya},   32'h0);
    check("rst_busyB", {31'h0, busyb},   32'h0);
    check("rst_count", {26'h0, pcount},  32'h0);
    check("rst_coll",  {31'h0, coll},    32'h0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;
    idle_read(5, 9);
    @(posedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
